// File: rtl/reg8file_ctrl.sv
// Write-port arbiter and snapshot scan sequencer for an 8 x 8-bit register file.
// Two requesters share the write port round-robin; a scan streams every register out in order.
module reg8file_ctrl #(
  parameter int DW   = 8,
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rf_en,
  output logic [AW-1:0] rf_wsel,
  output logic [DW-1:0] rf_d,
  output logic [AW-1:0] rf_rsel,
  input  logic [DW-1:0] rf_q,
  input  logic          scan_start,
  output logic          scan_busy,
  output logic          scan_valid,
  output logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          prio_a_q, prio_a_d;
  logic          rf_en_q, rf_en_d;
  logic [AW-1:0] rf_wsel_q, rf_wsel_d;
  logic [DW-1:0] rf_d_q, rf_d_d;
  logic          scan_valid_q, scan_valid_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic [DW-1:0] scan_data_q, scan_data_d;
  logic          wr_open_s;
  logic          a_fire_s;
  logic          b_fire_s;

  // Writes are only admitted in IDLE when no scan is being requested, keeping the snapshot clean.
  assign wr_open_s = (state_q == IDLE) && !scan_start;
  assign a_ready   = wr_open_s && a_valid && (!b_valid || prio_a_q);
  assign b_ready   = wr_open_s && b_valid && (!a_valid || !prio_a_q);
  assign a_fire_s  = a_valid && a_ready;
  assign b_fire_s  = b_valid && b_ready;

  assign rf_rsel    = (state_q == SCAN) ? cnt_q : rd_addr;
  assign scan_busy  = (state_q == SCAN);
  assign rf_en      = rf_en_q;
  assign rf_wsel    = rf_wsel_q;
  assign rf_d       = rf_d_q;
  assign scan_valid = scan_valid_q;
  assign scan_addr  = scan_addr_q;
  assign scan_data  = scan_data_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prio_a_d     = prio_a_q;
    rf_en_d      = a_fire_s || b_fire_s;
    rf_wsel_d    = rf_wsel_q;
    rf_d_d       = rf_d_q;
    scan_valid_d = 1'b0;
    scan_addr_d  = scan_addr_q;
    scan_data_d  = scan_data_q;

    // The pointer moves only on a completed transfer, towards the other requester.
    if (a_fire_s) begin
      rf_wsel_d = a_addr;
      rf_d_d    = a_data;
      prio_a_d  = 1'b0;
    end else if (b_fire_s) begin
      rf_wsel_d = b_addr;
      rf_d_d    = b_data;
      prio_a_d  = 1'b1;
    end else begin
      rf_wsel_d = rf_wsel_q;
      rf_d_d    = rf_d_q;
    end

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        scan_valid_d = 1'b1;
        scan_addr_d  = cnt_q;
        scan_data_d  = rf_q;
        cnt_d        = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset leaves A with priority so it wins the first tie.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      cnt_q        <= {AW{1'b0}};
      prio_a_q     <= 1'b1;
      rf_en_q      <= 1'b0;
      rf_wsel_q    <= {AW{1'b0}};
      rf_d_q       <= {DW{1'b0}};
      scan_valid_q <= 1'b0;
      scan_addr_q  <= {AW{1'b0}};
      scan_data_q  <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prio_a_q     <= prio_a_d;
      rf_en_q      <= rf_en_d;
      rf_wsel_q    <= rf_wsel_d;
      rf_d_q       <= rf_d_d;
      scan_valid_q <= scan_valid_d;
      scan_addr_q  <= scan_addr_d;
      scan_data_q  <= scan_data_d;
    end
  end

endmodule

// File: tb/tb_reg8file_ctrl.sv
// Directed bench for reg8file_ctrl with a behavioural register file and write/scan scoreboards.
module tb_reg8file_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       a_valid, b_valid, scan_start;
  logic [2:0] a_addr, b_addr, rd_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, rf_en, scan_busy, scan_valid;
  logic [2:0] rf_wsel, rf_rsel, scan_addr;
  logic [7:0] rf_d, rf_q, scan_data;

  logic [7:0]  rf_mem  [8];
  logic [7:0]  exp_mem [8];
  logic [10:0] wq [$];
  logic [10:0] sq [$];
  logic        exp_prio_a;
  int          total  = 0;
  int          passed = 0;

  reg8file_ctrl #(.DW(8), .AW(3), .NREG(8)) dut (
    .clk(clk), .clr_n(clr_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rd_addr(rd_addr),
    .rf_en(rf_en), .rf_wsel(rf_wsel), .rf_d(rf_d), .rf_rsel(rf_rsel), .rf_q(rf_q),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_addr(scan_addr), .scan_data(scan_data)
  );

  always #5 clk = ~clk;

  // Behavioural register file: commits on the rising edge, reads combinationally.
  always @(posedge clk) begin
    if (rf_en === 1'b1) rf_mem[rf_wsel] <= rf_d;
  end
  assign rf_q = rf_mem[rf_rsel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Write and scan scoreboards, compared away from the active edge.
  always @(negedge clk) begin
    logic [10:0] w;
    logic [10:0] s;
    check("rf_en", rf_en, wq.size() != 0);
    if (rf_en === 1'b1 && wq.size() != 0) begin
      w = wq.pop_front();
      check("rf_wsel", rf_wsel, w[10:8]);
      check("rf_d", rf_d, w[7:0]);
    end
    if (scan_valid === 1'b1) begin
      check("scan_pending", sq.size() != 0, 1'b1);
      if (sq.size() != 0) begin
        s = sq.pop_front();
        check("scan_addr", scan_addr, s[10:8]);
        check("scan_data", scan_data, s[7:0]);
      end
    end
  end

  task automatic push_scan();
    for (int i = 0; i < 8; i++) sq.push_back({3'(i), exp_mem[i]});
  endtask

  // One cycle: drive inputs after the falling edge, check readies/busy, record expected writes.
  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                       input logic ss, input logic busy);
    logic ea, eb;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    scan_start = ss;
    #1;
    ea = !busy && !ss && av && (!bv || exp_prio_a);
    eb = !busy && !ss && bv && (!av || !exp_prio_a);
    check("scan_busy", scan_busy, busy);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    if (ea) begin
      wq.push_back({aa, ad}); exp_mem[aa] = ad; exp_prio_a = 1'b0;
    end else if (eb) begin
      wq.push_back({ba, bd}); exp_mem[ba] = bd; exp_prio_a = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 8'h00; exp_mem[i] = 8'h00;
    end
    a_valid = 1'b0; a_addr = 3'd0; a_data = 8'h00;
    b_valid = 1'b0; b_addr = 3'd0; b_data = 8'h00;
    rd_addr = 3'd0; scan_start = 1'b0; exp_prio_a = 1'b1;

    #1 clr_n = 1'b0;
    #2;
    check("rst_rf_en", rf_en, 1'b0);
    check("rst_rf_wsel", rf_wsel, 3'd0);
    check("rst_rf_d", rf_d, 8'h00);
    check("rst_scan_busy", scan_busy, 1'b0);
    check("rst_scan_valid", scan_valid, 1'b0);
    check("rst_scan_addr", scan_addr, 3'd0);
    check("rst_scan_data", scan_data, 8'h00);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;

    // Single A write, then idle.
    drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("rd_rsel", rf_rsel, 3'd0);

    // A B-only write moves the pointer back to A, then a 4-cycle tie alternates A,B,A,B.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    // Preload 0x10..0x17 and scan with A held valid.
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    push_scan();
    drive(1'b1, 3'd7, 8'hEE, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'd7, 8'hEE, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("scan1_done", sq.size(), 0);

    // Write reg 0 on the edge before scan_start; first beat must carry it.
    drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    push_scan();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("scan2_done", sq.size(), 0);

    // Make B the next tie winner, then reset during scan beat 4.
    drive(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    push_scan();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    check("abort_busy", scan_busy, 1'b0);
    check("abort_valid", scan_valid, 1'b0);
    check("abort_rf_en", rf_en, 1'b0);
    sq.delete();
    wq.delete();
    exp_prio_a = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    drive(1'b1, 3'd5, 8'hA5, 1'b1, 3'd6, 8'hB6, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    // scan_start held across a full scan: a second scan follows, no grants in between.
    push_scan();
    drive(1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, 1'b1, 1'b1);
    push_scan();
    drive(1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("scan3_done", sq.size(), 0);
    check("writes_done", wq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
